// File: rtl/rtc_sweep_ctrl.sv
// Temperature-sweep resistance compensator.
// For each sweep point: R(T) = r_nom * (1 + tc1*dT + tc2*dT^2), with one shared signed multiplier
// time-multiplexed across four multiply states, and the result clamped to the RW-bit range.
module rtc_sweep_ctrl #(
    parameter int unsigned RW = 24,
    parameter int unsigned TW = 12,
    parameter int unsigned NW = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [RW-1:0]        r_nom,
    input  logic signed [TW-1:0] tnom,
    input  logic signed [TW-1:0] temp_start,
    input  logic signed [TW-1:0] temp_step,
    input  logic signed [15:0]   tc1,
    input  logic signed [15:0]   tc2,
    input  logic [NW-1:0]        n_steps,
    input  logic                 out_ready,
    output logic                 out_valid,
    output logic [RW-1:0]        out_r,
    output logic signed [TW-1:0] out_temp,
    output logic [NW-1:0]        out_idx,
    output logic                 out_sat,
    output logic                 busy,
    output logic                 done
);

    localparam logic [2:0] StIdle = 3'd0;
    localparam logic [2:0] StMul1 = 3'd1;
    localparam logic [2:0] StMul2 = 3'd2;
    localparam logic [2:0] StMul3 = 3'd3;
    localparam logic [2:0] StMul4 = 3'd4;
    localparam logic [2:0] StEmit = 3'd5;

    // dT width, dT^2 width, multiplier operand B width, accumulator width, product width.
    localparam int unsigned DW  = TW + 1;
    localparam int unsigned QW  = 2 * DW;
    localparam int unsigned BW0 = (RW + 1 > QW) ? RW + 1 : QW;
    localparam int unsigned BW  = (BW0 > 16) ? BW0 : 16;
    localparam int unsigned FW  = 48;
    localparam int unsigned PW  = FW + BW;
    localparam int unsigned SW  = PW - 24;

    localparam logic signed [FW-1:0] FOne = {{(FW - 25){1'b0}}, 1'b1, 24'b0};

    logic [2:0]           state_q, state_d;
    logic [RW-1:0]        rnom_q;
    logic signed [TW-1:0] tnom_q, step_q, temp_q;
    logic signed [15:0]   tc1_q, tc2_q;
    logic [NW-1:0]        n_q, idx_q;
    logic signed [FW-1:0] l_q, f_q;
    logic signed [BW-1:0] q_q;
    logic [RW-1:0]        out_r_q;
    logic                 out_sat_q, done_q;

    logic signed [DW-1:0] dt;
    logic signed [FW-1:0] mul_a, f_next;
    logic signed [BW-1:0] mul_b;
    logic signed [PW-1:0] prod;
    logic [SW-1:0]        res;
    logic [RW-1:0]        clamp_r;
    logic                 clamp_sat, last, hs;

    assign dt     = DW'(temp_q) - DW'(tnom_q);
    assign prod   = PW'(mul_a) * PW'(mul_b);
    assign f_next = FOne + (l_q <<< 8) + $signed(prod[FW-1:0]);
    // Arithmetic shift right by 24 of the full product is a floor divide by 2^24.
    assign res    = prod[PW-1:24];
    assign last   = (idx_q == n_q - NW'(1));
    assign hs     = (state_q == StEmit) && out_ready && !abort;

    // Route operands of the shared multiplier according to the current multiply step.
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        case (state_q)
            StMul1: begin mul_a = FW'(dt);    mul_b = BW'(tc1_q); end
            StMul2: begin mul_a = FW'(dt);    mul_b = BW'(dt);    end
            StMul3: begin mul_a = FW'(tc2_q); mul_b = q_q;        end
            StMul4: begin mul_a = f_q;        mul_b = BW'($signed({1'b0, rnom_q})); end
            default: ;
        endcase
    end

    // Clamp the scaled product into the unsigned RW-bit output range.
    always_comb begin
        clamp_r   = res[RW-1:0];
        clamp_sat = 1'b0;
        if (res[SW-1]) begin
            clamp_r   = '0;
            clamp_sat = 1'b1;
        end else if (|res[SW-2:RW]) begin
            clamp_r   = '1;
            clamp_sat = 1'b1;
        end
    end

    // Next-state logic; abort overrides everything outside IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: if (start && !abort && n_steps != '0) state_d = StMul1;
            StMul1: state_d = StMul2;
            StMul2: state_d = StMul3;
            StMul3: state_d = StMul4;
            StMul4: state_d = StEmit;
            StEmit: if (out_ready) state_d = last ? StIdle : StMul1;
            default: state_d = StIdle;
        endcase
        if (state_q != StIdle && abort) state_d = StIdle;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    // Configuration capture, per-step datapath registers and sweep bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rnom_q    <= '0;
            tnom_q    <= '0;
            step_q    <= '0;
            temp_q    <= '0;
            tc1_q     <= '0;
            tc2_q     <= '0;
            n_q       <= '0;
            idx_q     <= '0;
            l_q       <= '0;
            q_q       <= '0;
            f_q       <= '0;
            out_r_q   <= '0;
            out_sat_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start && !abort) begin
                        rnom_q <= r_nom;
                        tnom_q <= tnom;
                        step_q <= temp_step;
                        temp_q <= temp_start;
                        tc1_q  <= tc1;
                        tc2_q  <= tc2;
                        n_q    <= n_steps;
                        idx_q  <= '0;
                        done_q <= (n_steps == '0);
                    end
                end
                StMul1: l_q <= prod[FW-1:0];
                StMul2: q_q <= prod[BW-1:0];
                StMul3: f_q <= f_next;
                StMul4: begin
                    out_r_q   <= clamp_r;
                    out_sat_q <= clamp_sat;
                end
                StEmit: begin
                    if (hs) begin
                        if (last) begin
                            done_q <= 1'b1;
                        end else begin
                            idx_q  <= idx_q + NW'(1);
                            temp_q <= temp_q + step_q;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_valid = (state_q == StEmit);
    assign busy      = (state_q != StIdle);
    assign done      = done_q;
    assign out_r     = out_r_q;
    assign out_sat   = out_sat_q;
    assign out_temp  = temp_q;
    assign out_idx   = idx_q;

endmodule

// File: tb/tb_rtc_sweep_ctrl.sv
// Scoreboard bench for rtc_sweep_ctrl: stimulus pushes hand-computed points, a negedge monitor
// pops and compares on every output handshake.
module tb_rtc_sweep_ctrl;

    localparam int unsigned RW = 24;
    localparam int unsigned TW = 12;
    localparam int unsigned NW = 8;

    typedef struct packed {
        logic [RW-1:0] r;
        logic          sat;
        logic [TW-1:0] temp;
        logic [NW-1:0] idx;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n, start, abort, out_ready;
    logic [RW-1:0] r_nom;
    logic [TW-1:0] tnom, temp_start, temp_step;
    logic [15:0] tc1, tc2;
    logic [NW-1:0] n_steps;
    logic out_valid, out_sat, busy, done;
    logic [RW-1:0] out_r;
    logic [TW-1:0] out_temp;
    logic [NW-1:0] out_idx;

    int compared = 0;
    int mismatched = 0;
    exp_t sb[$];
    exp_t mon_e;

    rtc_sweep_ctrl #(.RW(RW), .TW(TW), .NW(NW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .r_nom(r_nom), .tnom(tnom), .temp_start(temp_start), .temp_step(temp_step),
        .tc1(tc1), .tc2(tc2), .n_steps(n_steps), .out_ready(out_ready),
        .out_valid(out_valid), .out_r(out_r), .out_temp(out_temp), .out_idx(out_idx),
        .out_sat(out_sat), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [63:0] act,
                                input logic [63:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endfunction

    // Monitor: a handshake completes at the next rising edge.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready && !abort) begin
            if (sb.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_output: got idx %0d, expected no output", out_idx);
            end else begin
                mon_e = sb.pop_front();
                chk("out_r", 64'(out_r), 64'(mon_e.r));
                chk("out_sat", 64'(out_sat), 64'(mon_e.sat));
                chk("out_temp", 64'(out_temp), 64'(mon_e.temp));
                chk("out_idx", 64'(out_idx), 64'(mon_e.idx));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int r, input bit sat, input int t, input int idx);
        exp_t e;
        e.r = RW'(r);
        e.sat = sat;
        e.temp = TW'(t);
        e.idx = NW'(idx);
        sb.push_back(e);
    endtask

    task automatic set_cfg(input int r, input int tn, input int ts, input int st,
                           input int c1, input int c2, input int n);
        r_nom = RW'(r);
        tnom = TW'(tn);
        temp_start = TW'(ts);
        temp_step = TW'(st);
        tc1 = 16'(c1);
        tc2 = 16'(c2);
        n_steps = NW'(n);
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        if (!out_valid) chk({name, "_valid_timeout"}, 64'(out_valid), 64'd1);
    endtask

    // Wait for the sweep to end, then expect a one-cycle done pulse.
    task automatic finish_sweep(input string name);
        int n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
        end
        chk({name, "_idle"}, 64'(busy), 64'd0);
        chk({name, "_done"}, 64'(done), 64'd1);
        tick();
        chk({name, "_done_low"}, 64'(done), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        bit seen;
        logic [63:0] cap;
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        out_ready = 1'b1;
        set_cfg(0, 0, 0, 0, 0, 0, 0);
        #12;
        chk("rst_outs", 64'({out_valid, busy, done, out_sat}), 64'd0);
        chk("rst_data", 64'({out_r, out_temp, out_idx}), 64'd0);
        rst_n = 1'b1;
        tick();

        // Linear sweep: 1000, 1039, 1079 ohm.
        set_cfg(1000, 27, 27, 10, 262, 0, 3);
        push(1000, 0, 27, 0);
        push(1039, 0, 37, 1);
        push(1079, 0, 47, 2);
        start = 1'b1;
        tick();
        start = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk("latency_edges", 64'(lat), 64'd5);
        finish_sweep("linear");

        // Saturation high and low.
        set_cfg(24'hFFFFFF, 0, 100, 0, 32767, 0, 1);
        push(24'hFFFFFF, 1, 100, 0);
        do_start();
        finish_sweep("sat_hi");
        set_cfg(24'hFFFFFF, 0, 3, 0, -32768, 0, 1);
        push(0, 1, 3, 0);
        do_start();
        finish_sweep("sat_lo");

        // Quadratic term, negative dT: F = 2^24 + 5000*256 + 2500*1000 -> 1225.
        set_cfg(1000, 0, -50, 0, -100, 1000, 1);
        push(1225, 0, -50, 0);
        do_start();
        finish_sweep("quad");

        // Backpressure: outputs hold for 6 stalled cycles.
        out_ready = 1'b0;
        set_cfg(1000, 27, 27, 10, 262, 0, 2);
        push(1000, 0, 27, 0);
        push(1039, 0, 37, 1);
        do_start();
        wait_valid("bp");
        cap = 64'({out_valid, out_r, out_temp, out_idx});
        chk("bp_first", cap, 64'({1'b1, 24'd1000, 12'd27, 8'd0}));
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("bp_hold", 64'({out_valid, out_r, out_temp, out_idx}), cap);
        end
        out_ready = 1'b1;
        finish_sweep("bp");

        // n_steps = 0: immediate done, never busy, no output.
        set_cfg(1000, 27, 27, 10, 262, 0, 0);
        do_start();
        chk("n0_busy", 64'(busy), 64'd0);
        chk("n0_done", 64'(done), 64'd1);
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (out_valid || busy || done) seen = 1'b1;
        end
        chk("n0_quiet", 64'(seen), 64'd0);

        // Abort in MUL2 of point 1; start and config changes mid-sweep are ignored.
        set_cfg(1000, 27, 27, 10, 262, 0, 3);
        push(1000, 0, 27, 0);
        do_start();
        start = 1'b1;
        set_cfg(5000, 0, 90, 1, 0, 0, 1);
        tick();
        start = 1'b0;
        wait_valid("abort");
        tick();
        tick();
        chk("abort_idx", 64'(out_idx), 64'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_idle", 64'({busy, out_valid, done}), 64'd0);
        tick();
        chk("abort_no_done", 64'(done), 64'd0);

        // Full sweep after abort.
        set_cfg(1000, 27, 27, 10, 262, 0, 3);
        push(1000, 0, 27, 0);
        push(1039, 0, 37, 1);
        push(1079, 0, 47, 2);
        do_start();
        finish_sweep("post_abort");

        // Asynchronous reset in EMIT, then restart from idx 0.
        out_ready = 1'b0;
        set_cfg(1000, 27, 37, 10, 262, 0, 2);
        do_start();
        wait_valid("rst");
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_ctl", 64'({out_valid, busy, done, out_sat}), 64'd0);
        chk("rst_async_data", 64'({out_r, out_temp, out_idx}), 64'd0);
        rst_n = 1'b1;
        tick();
        chk("rst_idle", 64'(busy), 64'd0);
        out_ready = 1'b1;
        set_cfg(1000, 27, 37, 10, 262, 0, 1);
        push(1039, 0, 37, 0);
        do_start();
        finish_sweep("rst_restart");

        tick();
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
